// File: rtl/io_pkg.sv
// Shared constants and types for the processor input port and its byte FIFO.
package io_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t IDLE_BUS = 8'h00;

  // Occupancy counter width: one extra bit so that "full" (== DEPTH) is representable.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/input_port_ctrl_if.sv
// Device/processor side signals of the input port, bundled for the controller and its environment.
import io_pkg::*;

interface input_port_ctrl_if #(
  parameter int unsigned DEPTH = io_pkg::DEPTH_DEF
) ();

  localparam int unsigned CW = io_pkg::count_w(DEPTH);

  logic          dev_strobe;
  byte_t         dev_data;
  logic          ovf_clr;
  logic          in_dev_ack;
  logic          in_dev_hs;
  byte_t         input_bus;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  // Environment side: drives the device and processor requests, observes the port.
  modport master (
    output dev_strobe, dev_data, ovf_clr, in_dev_ack,
    input  in_dev_hs, input_bus, fifo_count, overflow
  );

  // Controller side.
  modport slave (
    input  dev_strobe, dev_data, ovf_clr, in_dev_ack,
    output in_dev_hs, input_bus, fifo_count, overflow
  );

endinterface

// File: rtl/input_port_ctrl_byte_fifo.sv
// Byte FIFO: storage, wrapping pointers and occupancy count. Callers qualify push/pop.
import io_pkg::*;

module byte_fifo #(
  parameter int unsigned DEPTH = io_pkg::DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              push,
  input  logic                              pop,
  input  byte_t                             din,
  output byte_t                             head,
  output logic [io_pkg::count_w(DEPTH)-1:0] count,
  output logic                              full,
  output logic                              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = io_pkg::count_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  byte_t         mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Storage write; contents are never cleared, stale bytes are unreachable via count.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/input_port_ctrl.sv
// Processor input port: buffers device bytes, presents the oldest one on input_bus and pops
// on each rising edge of in_dev_ack; a byte arriving with the FIFO full is dropped and flagged.
import io_pkg::*;

module input_port_ctrl #(
  parameter int unsigned DEPTH = io_pkg::DEPTH_DEF
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  input_port_ctrl_if.slave         io
);

  localparam int unsigned CW = io_pkg::count_w(DEPTH);

  logic          ack_prev_r;
  logic          overflow_r;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  byte_t         head_s;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;

  // Qualify FIFO operations; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (io.in_dev_ack && !ack_prev_r && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (io.dev_strobe) begin
      push_s = !full_s || pop_s;
      drop_s = full_s && !pop_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (g_clk),
    .clr   (g_clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (io.dev_data),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Ack edge history and sticky overflow; a drop outranks a same-cycle clear request.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      ack_prev_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      ack_prev_r <= io.in_dev_ack;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (io.ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Outputs derive only from registered state, never from the device inputs.
  always_comb begin
    io.in_dev_hs  = !empty_s;
    io.fifo_count = count_s;
    io.overflow   = overflow_r;
    if (empty_s) begin
      io.input_bus = IDLE_BUS;
    end else begin
      io.input_bus = head_s;
    end
  end

endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4; FIFO entries, power of two, 2..16.
REQ-002 SHALL have port g_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port g_clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port dev_strobe  input  1  external device: one-cycle "byte present" pulse.
REQ-005 SHALL have port dev_data  input  8  external device byte, valid when dev_strobe=1.
REQ-006 SHALL have port ovf_clr  input  1  clears sticky overflow flag.
REQ-007 SHALL have port in_dev_ack  input  1  processor: byte consumed (edge-qualified).
REQ-008 SHALL have port in_dev_hs  output  1  processor: byte available on input_bus.
REQ-009 SHALL have port input_bus  output  8  processor: head-of-FIFO byte.
REQ-010 SHALL have port fifo_count  output  clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky: a strobed byte was dropped.

Function
REQ-012 SHALL push dev_data on any cycle with dev_strobe=1 and (count<DEPTH, or a pop occurs in that cycle).
REQ-013 SHALL drop the byte and set overflow when dev_strobe=1, count==DEPTH and no pop in that cycle; FIFO contents unchanged.
REQ-014 SHALL register ack_prev each cycle; pop event = in_dev_ack=1 and ack_prev=0 and in_dev_hs=1.
REQ-015 SHALL ignore in_dev_ack held high across cycles (one pop per rising edge only).
REQ-016 SHALL ignore an ack rising edge while in_dev_hs=0 (empty); ack_prev still updates.
REQ-017 SHALL drive in_dev_hs = (count!=0), from registered count; a push at edge N raises in_dev_hs after edge N (1-cycle latency strobe->hs).
REQ-018 SHALL drive input_bus = head entry when count!=0, else 8'h00.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; head moves to next-oldest byte.
REQ-020 SHALL, on simultaneous push and pop with count==0, treat as push only (pop ignored per REQ-016).
REQ-021 SHALL wrap read and write pointers modulo DEPTH; count range 0..DEPTH inclusive.
REQ-022 SHALL preserve byte order strictly FIFO; no byte duplicated or reordered.
REQ-023 SHALL clear overflow when ovf_clr=1; if overflow set-condition and ovf_clr coincide, overflow ends at 1 (set wins).

Reset
REQ-024 SHALL, while g_clr=1 at a rising edge, set count=0, pointers=0, ack_prev=0, overflow=0, ignoring strobe/ack that cycle.
REQ-025 SHALL present in_dev_hs=0, input_bus=8'h00, fifo_count=0, overflow=0 after reset.
REQ-026 SHALL discard buffered bytes on reset mid-operation; first post-reset strobe becomes new head.
REQ-027 SHALL not require clearing FIFO storage array on reset.

Structure
REQ-028 SHALL place DEPTH default, byte width (8) and idle bus value (8'h00) in shared package io_pkg.
REQ-029 SHALL implement storage and pointers in one sub-module byte_fifo (push, pop, head, count, full, empty); edge detect, overflow and output muxing in input_port_ctrl.
REQ-030 SHALL contain no combinational path from dev_strobe/dev_data to in_dev_hs/input_bus.

Verification
REQ-031 Reset then strobe 0x0A -> next cycle in_dev_hs=1, input_bus=0x0A, fifo_count=1; ack pulse -> hs=0, bus=0x00, count=0.
REQ-032 Strobe 0x11,0x22,0x33,0x44,0x55 (DEPTH=4), no ack -> count=4, overflow=1, pops return 0x11..0x44 in order, then hs=0.
REQ-033 Full FIFO, strobe 0x99 same cycle as ack rising edge -> no overflow, count stays 4, last byte popped is 0x99.
REQ-034 Two bytes buffered, in_dev_ack held high 5 cycles -> exactly one pop, count=1; ack low then high -> second pop, count=0.
REQ-035 Three bytes buffered, overflow=1, assert g_clr one cycle with strobe and ack active -> all outputs zero, overflow=0, nothing pushed.
REQ-036 Overflow set, ovf_clr=1 alone -> overflow=0; ovf_clr with drop-condition same cycle -> overflow=1.
